read_request_splitter: RTL and testbench
========================================

Name: read_request_splitter

Overview:
- Sits between working_fifo (job descriptors) and rd_fifo (per-burst job tags).
- Pops one {src_addr, rd_length, job_id} descriptor at a time and splits it into AXI4 INCR read bursts on the memory AR channel.
- Bursts never cross a 4 KB boundary and never exceed MAX_BURST_BEATS.
- For every accepted AR handshake, writes the job_id into the tag FIFO, so the read-data path can attribute returning beats.

Parameters:
- BEAT_BYTES, 64, bytes per data beat (512-bit bus); power of two.
- MAX_BURST_BEATS, 64, maximum beats per burst (arlen ≤ MAX_BURST_BEATS-1).
- BOUNDARY_BYTES, 4096, bursts must not cross a multiple of this.
- ARID_VALUE, 0, constant driven on m_axi_arid.

Ports:
- clk  in  1  single clock.
- srst  in  1  synchronous, active-high reset.
- job_valid  in  1  descriptor available (working_fifo valid_out).
- job_src_addr  in  64  byte start address.
- job_rd_length  in  26  length in bytes.
- job_id  in  16  job identifier.
- job_rd  out  1  one-cycle pop of the current descriptor.
- m_axi_araddr  out  64  burst address, BEAT_BYTES-aligned.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  log2(BEAT_BYTES), constant.
- m_axi_arburst  out  2  2'b01 (INCR), constant.
- m_axi_arid  out  4  ARID_VALUE.
- m_axi_arvalid  out  1  request valid.
- m_axi_arready  in  1  request accepted.
- tag_almost_full  in  1  tag FIFO prog_full.
- tag_wr  out  1  tag write strobe.
- tag_job_id  out  16  tag data.
- busy  out  1  descriptor in progress (state ≠ IDLE).

Behaviour:
- Reset values: job_rd=0, m_axi_arvalid=0, m_axi_araddr=0, m_axi_arlen=0, tag_wr=0, tag_job_id=0, busy=0, state=IDLE.
- srst mid-burst abandons the descriptor; no further AR or tag is issued for it.
- Beat math:
  - start_beat = src_addr>>log2(BEAT_BYTES).
  - end_beat = (src_addr+rd_length-1)>>log2(BEAT_BYTES).
  - remaining = end_beat-start_beat+1, held in a 21-bit counter.
  - The first burst address is src_addr rounded down to BEAT_BYTES. The intra-beat offset is the consumer's responsibility.
- Per burst: beats = min(remaining, MAX_BURST_BEATS, beats_to_boundary), where beats_to_boundary = (BOUNDARY_BYTES - (cur_addr mod BOUNDARY_BYTES))/BEAT_BYTES.
- Address arithmetic is 64-bit and wraps modulo 2^64; wrap is not flagged.
- FSM IDLE:
  - job_valid=1: job_rd=1 combinationally that cycle; capture the descriptor.
  - rd_length=0: drop the job (no AR, no tag) and stay IDLE.
  - Otherwise: go to CALC.
- FSM CALC:
  - Register cur_addr and beats; set arlen=beats-1.
  - tag_almost_full=1: stay in CALC.
  - Otherwise: set arvalid=1 (registered) and go to ISSUE.
- FSM ISSUE:
  - Hold araddr, arlen and arvalid stable until arready. Do not drop arvalid even if tag_almost_full rises (AXI rule).
  - On arvalid&arready:
    - tag_wr=1 combinationally that cycle; tag_job_id=captured id.
    - arvalid←0; cur_addr += beats*BEAT_BYTES; remaining -= beats.
    - remaining now 0: go to IDLE. Otherwise: go to CALC.
- Latency:
  - Descriptor pop to first arvalid: 2 cycles.
  - Handshake to next arvalid: 2 cycles.
  - Tag write is coincident with the handshake.
- job_rd is asserted only in IDLE, so at most one descriptor is outstanding. The next pop can occur the cycle after the final handshake.
- job_valid seen in any state other than IDLE is ignored.

Decomposition:
- Shared package:
  - AXI constants: INCR=2'b01, arsize function log2.
  - Descriptor widths: ADDR_W=64, LEN_W=26, JOBID_W=16.
  - Beat-count width function.
- One natural sub-module, burst_len_calc: combinational min(remaining, max, to-boundary) producing beats.
- The FSM and counters stay in the top module.

Test Plan:
- addr=0x1000, len=8192, arready=1 → two ARs: (0x1000, arlen=63), (0x2000, arlen=63). Two tag_wr with the job id. busy low after the second handshake.
- addr=0x0FF0, len=0x20 → two ARs (0x0FC0, arlen=0) and (0x1000, arlen=0), split at the 4 KB boundary.
- len=0, job_id=0x55 → job_rd pulse, no arvalid, no tag_wr. The next descriptor is processed normally.
- tag_almost_full=1 throughout CALC → arvalid stays 0. Deassert → arvalid rises the next cycle.
- arready held low 5 cycles with arvalid=1 → araddr/arlen/arvalid stable. Assert tag_almost_full during the wait → arvalid still held. Handshake then proceeds.
- srst asserted during ISSUE of burst 1 of 3 → all outputs at reset values next cycle. No further ARs. A new descriptor after reset starts cleanly.

Source files
------------

// File: rtl/read_request_splitter_pkg.sv
// Shared types, widths and AXI helpers for the read request splitter.
package read_request_splitter_pkg;

    localparam int ADDR_W  = 64;
    localparam int LEN_W   = 26;
    localparam int JOBID_W = 16;
    localparam int REM_W   = 21;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE
    } state_t;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [2:0] axi_arsize(input int beat_bytes);
        return 3'(log2(beat_bytes));
    endfunction

    // Width able to hold the value max_beats itself.
    function automatic int beat_cnt_w(input int max_beats);
        return log2(max_beats + 1);
    endfunction

endpackage

// File: rtl/read_request_splitter_burst_len_calc.sv
// Burst length: min(remaining beats, max burst beats, beats left to boundary).
module read_request_splitter_burst_len_calc
    import read_request_splitter_pkg::*;
#(
    parameter int BEAT_BYTES      = 64,
    parameter int MAX_BURST_BEATS = 64,
    parameter int BOUNDARY_BYTES  = 4096,
    localparam int BEAT_LSB  = log2(BEAT_BYTES),
    localparam int BOUND_LSB = log2(BOUNDARY_BYTES),
    localparam int CNT_W     = beat_cnt_w(MAX_BURST_BEATS)
) (
    input  logic [BOUND_LSB-BEAT_LSB-1:0] beat_off,
    input  logic [REM_W-1:0]              remaining,
    output logic [CNT_W-1:0]              beats
);

    logic [REM_W-1:0] to_bnd;
    logic [REM_W-1:0] lim;

    always_comb begin
        to_bnd = REM_W'(BOUNDARY_BYTES / BEAT_BYTES) - REM_W'(beat_off);
        lim    = remaining;
        if (REM_W'(MAX_BURST_BEATS) < lim) lim = REM_W'(MAX_BURST_BEATS);
        if (to_bnd < lim) lim = to_bnd;
        beats = CNT_W'(lim);
    end

endmodule

// File: rtl/read_request_splitter.sv
// Splits job descriptors into AXI4 INCR read bursts and tags each burst.
module read_request_splitter
    import read_request_splitter_pkg::*;
#(
    parameter int         BEAT_BYTES      = 64,
    parameter int         MAX_BURST_BEATS = 64,
    parameter int         BOUNDARY_BYTES  = 4096,
    parameter logic [3:0] ARID_VALUE      = 4'd0
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               job_valid,
    input  logic [ADDR_W-1:0]  job_src_addr,
    input  logic [LEN_W-1:0]   job_rd_length,
    input  logic [JOBID_W-1:0] job_id,
    output logic               job_rd,
    output logic [ADDR_W-1:0]  m_axi_araddr,
    output logic [7:0]         m_axi_arlen,
    output logic [2:0]         m_axi_arsize,
    output logic [1:0]         m_axi_arburst,
    output logic [3:0]         m_axi_arid,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic               tag_almost_full,
    output logic               tag_wr,
    output logic [JOBID_W-1:0] tag_job_id,
    output logic               busy
);

    localparam int BEAT_LSB  = log2(BEAT_BYTES);
    localparam int BOUND_LSB = log2(BOUNDARY_BYTES);
    localparam int CNT_W     = beat_cnt_w(MAX_BURST_BEATS);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  cur_addr;
    logic [REM_W-1:0]   remaining;
    logic [CNT_W-1:0]   beats;
    logic [CNT_W-1:0]   beats_q;
    logic [JOBID_W-1:0] job_id_q;
    logic [ADDR_W-1:0]  last_addr;
    logic [REM_W-1:0]   job_span;
    logic               hs;

    assign last_addr = job_src_addr + ADDR_W'(job_rd_length) - ADDR_W'(1);
    assign job_span  = REM_W'((last_addr >> BEAT_LSB) - (job_src_addr >> BEAT_LSB))
                     + REM_W'(1);
    assign hs        = m_axi_arvalid & m_axi_arready;

    assign m_axi_arsize  = axi_arsize(BEAT_BYTES);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arid    = ARID_VALUE;
    assign tag_job_id    = job_id_q;
    assign busy          = (state != ST_IDLE);

    read_request_splitter_burst_len_calc #(
        .BEAT_BYTES      (BEAT_BYTES),
        .MAX_BURST_BEATS (MAX_BURST_BEATS),
        .BOUNDARY_BYTES  (BOUNDARY_BYTES)
    ) u_burst_len_calc (
        .beat_off  (cur_addr[BOUND_LSB-1:BEAT_LSB]),
        .remaining (remaining),
        .beats     (beats)
    );

    always_ff @(posedge clk) begin
        if (srst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        job_rd    = 1'b0;
        tag_wr    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (job_valid && !srst) begin
                    job_rd = 1'b1;
                    if (job_rd_length != '0) state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (!tag_almost_full) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (hs && !srst) begin
                    tag_wr    = 1'b1;
                    state_nxt = (remaining == REM_W'(beats_q)) ? ST_IDLE : ST_CALC;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
            cur_addr      <= '0;
            remaining     <= '0;
            beats_q       <= '0;
            job_id_q      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        job_id_q  <= job_id;
                        cur_addr  <= {job_src_addr[ADDR_W-1:BEAT_LSB], {BEAT_LSB{1'b0}}};
                        remaining <= job_span;
                    end
                end
                ST_CALC: begin
                    m_axi_araddr <= cur_addr;
                    m_axi_arlen  <= 8'(beats) - 8'd1;
                    beats_q      <= beats;
                    if (!tag_almost_full) m_axi_arvalid <= 1'b1;
                end
                ST_ISSUE: begin
                    // Address wraps modulo 2^64 by construction.
                    if (hs) begin
                        m_axi_arvalid <= 1'b0;
                        cur_addr      <= cur_addr + (ADDR_W'(beats_q) << BEAT_LSB);
                        remaining     <= remaining - REM_W'(beats_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_read_request_splitter.sv
// Directed self-checking bench for read_request_splitter.
module tb_read_request_splitter;

    logic        clk;
    logic        srst;
    logic        job_valid;
    logic [63:0] job_src_addr;
    logic [25:0] job_rd_length;
    logic [15:0] job_id;
    logic        job_rd;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arid;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic        tag_almost_full;
    logic        tag_wr;
    logic [15:0] tag_job_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [71:0] ar_q[$];
    logic [15:0] tag_q[$];

    read_request_splitter dut (
        .clk             (clk),
        .srst            (srst),
        .job_valid       (job_valid),
        .job_src_addr    (job_src_addr),
        .job_rd_length   (job_rd_length),
        .job_id          (job_id),
        .job_rd          (job_rd),
        .m_axi_araddr    (m_axi_araddr),
        .m_axi_arlen     (m_axi_arlen),
        .m_axi_arsize    (m_axi_arsize),
        .m_axi_arburst   (m_axi_arburst),
        .m_axi_arid      (m_axi_arid),
        .m_axi_arvalid   (m_axi_arvalid),
        .m_axi_arready   (m_axi_arready),
        .tag_almost_full (tag_almost_full),
        .tag_wr          (tag_wr),
        .tag_job_id      (tag_job_id),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!srst) begin
            if (m_axi_arvalid && m_axi_arready)
                ar_q.push_back({m_axi_araddr, m_axi_arlen});
            if (tag_wr)
                tag_q.push_back(tag_job_id);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ar(input string tag, input int i,
                          input logic [63:0] a, input logic [7:0] l);
        logic [71:0] e;
        e = (i < ar_q.size()) ? ar_q[i] : '1;
        chk({tag, "_addr"}, e[71:8], a);
        chk({tag, "_len"}, 64'(e[7:0]), 64'(l));
    endtask

    task automatic chk_tag(input string tag, input int i, input logic [15:0] id);
        logic [15:0] t;
        t = (i < tag_q.size()) ? tag_q[i] : 16'hffff;
        chk(tag, 64'(t), 64'(id));
    endtask

    task automatic clear_logs();
        ar_q.delete();
        tag_q.delete();
    endtask

    task automatic pop(input logic [63:0] a, input logic [25:0] l,
                       input logic [15:0] id, input string tag);
        @(negedge clk);
        job_valid     = 1'b1;
        job_src_addr  = a;
        job_rd_length = l;
        job_id        = id;
        #1;
        chk({tag, "_job_rd"}, 64'(job_rd), 64'd1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_bound"}, 64'(n < 200), 64'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_job_rd"}, 64'(job_rd), 64'd0);
        chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        chk({tag, "_araddr"}, m_axi_araddr, 64'd0);
        chk({tag, "_arlen"}, 64'(m_axi_arlen), 64'd0);
        chk({tag, "_tag_wr"}, 64'(tag_wr), 64'd0);
        chk({tag, "_tag_id"}, 64'(tag_job_id), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        srst            = 1'b1;
        job_valid       = 1'b0;
        job_src_addr    = '0;
        job_rd_length   = '0;
        job_id          = '0;
        m_axi_arready   = 1'b0;
        tag_almost_full = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        chk("arsize", 64'(m_axi_arsize), 64'd6);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        chk("arid", 64'(m_axi_arid), 64'd0);
        srst = 1'b0;

        // Two full 64-beat bursts with exact cycle timing
        clear_logs();
        m_axi_arready = 1'b1;
        pop(64'h1000, 26'd8192, 16'h00A1, "t1");
        chk("t1_lat_vld0", 64'(m_axi_arvalid), 64'd0);
        chk("t1_lat_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_b0_vld", 64'(m_axi_arvalid), 64'd1);
        chk("t1_b0_addr", m_axi_araddr, 64'h1000);
        chk("t1_b0_len", 64'(m_axi_arlen), 64'd63);
        chk("t1_b0_tag_wr", 64'(tag_wr), 64'd1);
        chk("t1_b0_tag_id", 64'(tag_job_id), 64'h00A1);
        @(negedge clk);
        chk("t1_gap_vld0", 64'(m_axi_arvalid), 64'd0);
        @(negedge clk);
        chk("t1_b1_vld", 64'(m_axi_arvalid), 64'd1);
        chk("t1_b1_addr", m_axi_araddr, 64'h2000);
        chk("t1_b1_len", 64'(m_axi_arlen), 64'd63);
        @(negedge clk);
        chk("t1_busy_done", 64'(busy), 64'd0);
        chk("t1_ar_n", 64'(ar_q.size()), 64'd2);
        chk_ar("t1_ar0", 0, 64'h1000, 8'd63);
        chk_ar("t1_ar1", 1, 64'h2000, 8'd63);
        chk("t1_tag_n", 64'(tag_q.size()), 64'd2);
        chk_tag("t1_tag0", 0, 16'h00A1);
        chk_tag("t1_tag1", 1, 16'h00A1);

        // Unaligned start splitting at the 4 KB boundary
        clear_logs();
        pop(64'h0FF0, 26'h20, 16'h00B2, "t2");
        wait_idle("t2");
        chk("t2_ar_n", 64'(ar_q.size()), 64'd2);
        chk_ar("t2_ar0", 0, 64'h0FC0, 8'd0);
        chk_ar("t2_ar1", 1, 64'h1000, 8'd0);
        chk_tag("t2_tag0", 0, 16'h00B2);
        chk_tag("t2_tag1", 1, 16'h00B2);

        // Zero-length job is popped and dropped
        clear_logs();
        pop(64'h0, 26'd0, 16'h0055, "t3");
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_vld", 64'(m_axi_arvalid), 64'd0);
        repeat (3) @(negedge clk);
        chk("t3_ar_n", 64'(ar_q.size()), 64'd0);
        chk("t3_tag_n", 64'(tag_q.size()), 64'd0);
        pop(64'h40, 26'd64, 16'h0066, "t3b");
        wait_idle("t3b");
        chk("t3b_ar_n", 64'(ar_q.size()), 64'd1);
        chk_ar("t3b_ar0", 0, 64'h40, 8'd0);
        chk_tag("t3b_tag0", 0, 16'h0066);

        // Tag backpressure in CALC, then a stalled AR slot
        clear_logs();
        m_axi_arready   = 1'b0;
        tag_almost_full = 1'b1;
        pop(64'h3000, 26'h80, 16'h00C3, "t4");
        for (int i = 0; i < 4; i++) begin
            chk("t4_af_vld0", 64'(m_axi_arvalid), 64'd0);
            chk("t4_af_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        tag_almost_full = 1'b0;
        @(negedge clk);
        chk("t4_vld_rise", 64'(m_axi_arvalid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_vld", 64'(m_axi_arvalid), 64'd1);
            chk("t5_hold_addr", m_axi_araddr, 64'h3000);
            chk("t5_hold_len", 64'(m_axi_arlen), 64'd1);
            chk("t5_hold_tag_wr", 64'(tag_wr), 64'd0);
            if (i == 1) tag_almost_full = 1'b1;
            @(negedge clk);
        end
        m_axi_arready = 1'b1;
        #1;
        chk("t5_hs_tag_wr", 64'(tag_wr), 64'd1);
        chk("t5_hs_tag_id", 64'(tag_job_id), 64'h00C3);
        @(negedge clk);
        chk("t5_busy_done", 64'(busy), 64'd0);
        chk("t5_vld_done", 64'(m_axi_arvalid), 64'd0);
        tag_almost_full = 1'b0;
        chk("t5_ar_n", 64'(ar_q.size()), 64'd1);
        chk_ar("t5_ar0", 0, 64'h3000, 8'd1);

        // Reset in the middle of a three-burst job
        clear_logs();
        m_axi_arready = 1'b0;
        pop(64'h0, 26'd12288, 16'h00D4, "t6");
        @(negedge clk);
        chk("t6_issue_vld", 64'(m_axi_arvalid), 64'd1);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk_reset_outs("t6_rst");
        m_axi_arready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_ar_n", 64'(ar_q.size()), 64'd0);
        chk("t6_tag_n", 64'(tag_q.size()), 64'd0);
        pop(64'h5000, 26'd64, 16'h0077, "t6b");
        wait_idle("t6b");
        chk("t6b_ar_n", 64'(ar_q.size()), 64'd1);
        chk_ar("t6b_ar0", 0, 64'h5000, 8'd0);
        chk_tag("t6b_tag0", 0, 16'h0077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
